// File: rtl/lsd_result_streamer.sv
// lsd_result_streamer: dumps a completed Simple-LSD frame from the buffer read port
// as a 64-bit valid/ready stream (header word with the segment count, then one word
// per segment) while holding the buffer write-protected.
//
// Ports:
//   clock, n_rst                 clock, asynchronous active-low reset
//   in_ready, in_line_num        buffer has a complete frame / number of stored segments
//   in_start_v/h, in_end_v/h     segment read data, valid 1 cycle after out_rd_addr
//   out_rd_addr                  buffer read address
//   out_write_protect            freezes the buffer while high
//   out_data/valid/first/last    stream word, in_dst_ready is the sink's ready
//   out_busy, out_frame_cnt      FSM active / frames fully sent (wraps)
module lsd_result_streamer #(
   parameter int unsigned FRAME_HEIGHT = 525,
   parameter int unsigned FRAME_WIDTH  = 800,
   parameter int unsigned RAM_SIZE     = 4096
) (
   input  logic                              clock,
   input  logic                              n_rst,
   input  logic                              in_ready,
   input  logic [$clog2(RAM_SIZE)-1:0]       in_line_num,
   input  logic [$clog2(FRAME_HEIGHT)-1:0]   in_start_v,
   input  logic [$clog2(FRAME_WIDTH)-1:0]    in_start_h,
   input  logic [$clog2(FRAME_HEIGHT)-1:0]   in_end_v,
   input  logic [$clog2(FRAME_WIDTH)-1:0]    in_end_h,
   output logic [$clog2(RAM_SIZE)-1:0]       out_rd_addr,
   output logic                              out_write_protect,
   output logic [63:0]                       out_data,
   output logic                              out_valid,
   output logic                              out_first,
   output logic                              out_last,
   input  logic                              in_dst_ready,
   output logic                              out_busy,
   output logic [15:0]                       out_frame_cnt
);

   localparam int unsigned AW = $clog2(RAM_SIZE);

   typedef enum logic [2:0] {
      S_IDLE, S_LOCK, S_HEADER, S_ADDR, S_WAIT, S_SEND, S_RELEASE
   } state_e;

   state_e          state_q, state_d;
   logic            armed_q, armed_d;
   logic [AW-1:0]   count_q, count_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic            protect_q, protect_d;
   logic [63:0]     data_q, data_d;
   logic            valid_q, valid_d;
   logic            first_q, first_d;
   logic            last_q, last_d;
   logic            busy_q, busy_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic            hs_c;

   assign hs_c = valid_q & in_dst_ready;

   // State and output registers
   always_ff @(posedge clock or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= S_IDLE;
         armed_q     <= 1'b1;
         count_q     <= '0;
         idx_q       <= '0;
         rd_addr_q   <= '0;
         protect_q   <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         first_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         armed_q     <= armed_d;
         count_q     <= count_d;
         idx_q       <= idx_d;
         rd_addr_q   <= rd_addr_d;
         protect_q   <= protect_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         first_q     <= first_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Next-state and next-output logic; stream registers only change on
   // entry to a word state or on its handshake, so a stalled word holds.
   always_comb begin
      state_d     = state_q;
      armed_d     = armed_q;
      count_d     = count_q;
      idx_d       = idx_q;
      rd_addr_d   = rd_addr_q;
      data_d      = data_q;
      valid_d     = valid_q;
      first_d     = first_q;
      last_d      = last_q;
      frame_cnt_d = frame_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (in_ready && armed_q) state_d = S_LOCK;
         end
         S_LOCK: begin
            count_d = in_line_num;
            data_d  = {48'h0, 16'(in_line_num)};
            valid_d = 1'b1;
            first_d = 1'b1;
            last_d  = (in_line_num == '0);
            state_d = S_HEADER;
         end
         S_HEADER: begin
            if (hs_c) begin
               valid_d = 1'b0;
               first_d = 1'b0;
               last_d  = 1'b0;
               if (count_q == '0) begin
                  state_d = S_RELEASE;
               end else begin
                  idx_d     = '0;
                  rd_addr_d = '0;
                  state_d   = S_ADDR;
               end
            end
         end
         S_ADDR: begin
            // address is presented during this cycle; data returns in WAIT
            state_d = S_WAIT;
         end
         S_WAIT: begin
            data_d  = {16'(in_start_v), 16'(in_start_h), 16'(in_end_v), 16'(in_end_h)};
            valid_d = 1'b1;
            last_d  = (idx_q == AW'(count_q - AW'(1)));
            state_d = S_SEND;
         end
         S_SEND: begin
            if (hs_c) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               if (last_q) begin
                  state_d = S_RELEASE;
               end else begin
                  idx_d     = AW'(idx_q + AW'(1));
                  rd_addr_d = AW'(idx_q + AW'(1));
                  state_d   = S_ADDR;
               end
            end
         end
         S_RELEASE: begin
            frame_cnt_d = 16'(frame_cnt_q + 16'd1);
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // a low in_ready means the buffer has let go of the dumped frame
      if (!in_ready)                  armed_d = 1'b1;
      else if (state_q == S_RELEASE)  armed_d = 1'b0;

      protect_d = (state_d != S_IDLE);
      busy_d    = (state_d != S_IDLE);
   end

   assign out_rd_addr       = rd_addr_q;
   assign out_write_protect = protect_q;
   assign out_data          = data_q;
   assign out_valid         = valid_q;
   assign out_first         = first_q;
   assign out_last          = last_q;
   assign out_busy          = busy_q;
   assign out_frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_lsd_result_streamer.sv
// Testbench for lsd_result_streamer: a buffer model feeds segments, expected stream
// words are queued at stimulus time and a monitor compares every presented word.
module tb_lsd_result_streamer;

   localparam int unsigned VW = 10;
   localparam int unsigned HW = 10;
   localparam int unsigned AW = 12;

   typedef struct packed {
      logic [63:0] d;
      logic        f;
      logic        l;
   } word_t;

   logic          clock;
   logic          n_rst;
   logic          in_ready;
   logic [AW-1:0] in_line_num;
   logic [VW-1:0] in_start_v, in_end_v;
   logic [HW-1:0] in_start_h, in_end_h;
   logic [AW-1:0] out_rd_addr;
   logic          out_write_protect;
   logic [63:0]   out_data;
   logic          out_valid, out_first, out_last;
   logic          in_dst_ready;
   logic          out_busy;
   logic [15:0]   out_frame_cnt;

   logic [VW-1:0] mem_sv [16];
   logic [HW-1:0] mem_sh [16];
   logic [VW-1:0] mem_ev [16];
   logic [HW-1:0] mem_eh [16];

   word_t exp_q [$];
   int    n_checks = 0;
   int    n_fail   = 0;
   int    prot_cyc = 0;
   int    busy_cyc = 0;
   bit    bp_mode  = 1'b0;
   int    rdy_cyc  = 0;

   lsd_result_streamer dut (
      .clock             (clock),
      .n_rst             (n_rst),
      .in_ready          (in_ready),
      .in_line_num       (in_line_num),
      .in_start_v        (in_start_v),
      .in_start_h        (in_start_h),
      .in_end_v          (in_end_v),
      .in_end_h          (in_end_h),
      .out_rd_addr       (out_rd_addr),
      .out_write_protect (out_write_protect),
      .out_data          (out_data),
      .out_valid         (out_valid),
      .out_first         (out_first),
      .out_last          (out_last),
      .in_dst_ready      (in_dst_ready),
      .out_busy          (out_busy),
      .out_frame_cnt     (out_frame_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Buffer model: registered read, data valid one cycle after the address
   always @(posedge clock) begin
      in_start_v <= mem_sv[out_rd_addr[3:0]];
      in_start_h <= mem_sh[out_rd_addr[3:0]];
      in_end_v   <= mem_ev[out_rd_addr[3:0]];
      in_end_h   <= mem_eh[out_rd_addr[3:0]];
   end

   // Sink ready: always on, or 1 cycle on / 2 cycles off
   initial in_dst_ready = 1'b1;
   always @(posedge clock) begin
      #1;
      rdy_cyc = rdy_cyc + 1;
      if (bp_mode) in_dst_ready = ((rdy_cyc % 3) == 0);
      else         in_dst_ready = 1'b1;
   end

   always @(negedge clock) begin
      if (out_write_protect) prot_cyc = prot_cyc + 1;
      if (out_busy)          busy_cyc = busy_cyc + 1;
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every presented word must match the queue head (also while stalled)
   always @(negedge clock) begin
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", {out_data, out_first, out_last, 14'h0}, 80'h0);
         end else begin
            check("stream_word", {out_data, out_first, out_last, 14'h0},
                  {exp_q[0].d, exp_q[0].f, exp_q[0].l, 14'h0});
            if (in_dst_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic set_seg(input int i, input int sv, input int sh, input int ev, input int eh);
      mem_sv[i] = VW'(sv);
      mem_sh[i] = HW'(sh);
      mem_ev[i] = VW'(ev);
      mem_eh[i] = HW'(eh);
   endtask

   task automatic push_frame(input int n);
      word_t w;
      w.d = {48'h0, 16'(n)};
      w.f = 1'b1;
      w.l = (n == 0);
      exp_q.push_back(w);
      for (int i = 0; i < n; i++) begin
         w.d = {16'(mem_sv[i]), 16'(mem_sh[i]), 16'(mem_ev[i]), 16'(mem_eh[i])};
         w.f = 1'b0;
         w.l = (i == n - 1);
         exp_q.push_back(w);
      end
   endtask

   task automatic wait_busy(input logic level, input int bound, input string name);
      int k;
      k = 0;
      while (out_busy !== level && k < bound) begin
         @(negedge clock);
         k = k + 1;
      end
      if (out_busy !== level) check(name, 80'(out_busy), 80'(level));
   endtask

   // Dump one frame of n segments; optionally drop in_ready for one cycle first
   task automatic run_frame(input int n, input bit pulse);
      @(negedge clock);
      push_frame(n);
      in_line_num = AW'(n);
      prot_cyc    = 0;
      busy_cyc    = 0;
      if (pulse) begin
         in_ready = 1'b0;
         @(negedge clock);
      end
      in_ready = 1'b1;
      wait_busy(1'b1, 10, "frame_start_timeout");
      wait_busy(1'b0, 2000, "frame_done_timeout");
      @(negedge clock);
      check("queue_drained", 80'(exp_q.size()), 80'(0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      n_rst       = 1'b0;
      in_ready    = 1'b0;
      in_line_num = '0;
      for (int i = 0; i < 16; i++) set_seg(i, 0, 0, 0, 0);
      repeat (3) @(negedge clock);

      check("reset_stream", {out_data, out_valid, out_first, out_last, 13'h0}, 80'h0);
      check("reset_ctrl", {out_rd_addr, out_write_protect, out_busy, out_frame_cnt},
            80'h0);
      n_rst = 1'b1;
      @(negedge clock);

      // N=3, sink always ready
      set_seg(0, 10, 20, 30, 40);
      set_seg(1, 0, 0, 479, 639);
      set_seg(2, 5, 6, 7, 8);
      run_frame(3, 1'b0);
      check("n3_protect_cycles", 80'(prot_cyc), 80'(12));
      check("n3_busy_cycles", 80'(busy_cyc), 80'(12));
      check("n3_frame_cnt", 80'(out_frame_cnt), 80'(1));

      // in_ready held high: no second dump
      busy_cyc = 0;
      repeat (20) @(negedge clock);
      check("rearm_no_dump", 80'(busy_cyc), 80'(0));
      check("rearm_frame_cnt", 80'(out_frame_cnt), 80'(1));

      // N=0 after a one-cycle in_ready drop: exactly one dump
      run_frame(0, 1'b1);
      check("n0_busy_cycles", 80'(busy_cyc), 80'(3));
      check("n0_frame_cnt", 80'(out_frame_cnt), 80'(2));
      busy_cyc = 0;
      repeat (10) @(negedge clock);
      check("n0_single_dump", 80'(busy_cyc), 80'(0));

      // Backpressure: ready 1 on / 2 off
      set_seg(0, 1, 2, 3, 4);
      set_seg(1, 100, 200, 300, 400);
      set_seg(2, 524, 799, 0, 1);
      set_seg(3, 11, 22, 33, 44);
      bp_mode = 1'b1;
      run_frame(4, 1'b1);
      bp_mode = 1'b0;
      check("bp_frame_cnt", 80'(out_frame_cnt), 80'(3));

      // Reset during the second segment's SEND
      set_seg(0, 10, 20, 30, 40);
      set_seg(1, 0, 0, 479, 639);
      set_seg(2, 5, 6, 7, 8);
      @(negedge clock);
      push_frame(3);
      in_line_num = AW'(3);
      in_ready    = 1'b0;
      @(negedge clock);
      in_ready = 1'b1;
      k = 0;
      while (!(out_valid && !out_first && out_rd_addr == AW'(1)) && k < 200) begin
         @(negedge clock);
         k = k + 1;
      end
      check("reach_second_segment", 80'(out_rd_addr), 80'(1));
      #1 n_rst = 1'b0;
      #1;
      check("rst_mid_stream", {out_data, out_valid, out_first, out_last, 13'h0}, 80'h0);
      check("rst_mid_ctrl", {out_rd_addr, out_write_protect, out_busy, out_frame_cnt},
            80'h0);
      exp_q.delete();
      @(negedge clock);
      push_frame(3);
      n_rst = 1'b1;
      wait_busy(1'b1, 10, "restart_timeout");
      wait_busy(1'b0, 2000, "restart_done_timeout");
      @(negedge clock);
      check("restart_drained", 80'(exp_q.size()), 80'(0));
      check("restart_frame_cnt", 80'(out_frame_cnt), 80'(1));

      // Counter wrap
      @(negedge clock);
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clock);
      release dut.frame_cnt_q;
      run_frame(0, 1'b1);
      check("wrap_frame_cnt", 80'(out_frame_cnt), 80'(0));

      repeat (5) @(negedge clock);
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
